// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder
// Description : Multi-cycle adder. It adds DIGIT bits per clock using a ripple
//               slice and a carry flop, with start/busy/done handshaking.
//               Optional macro SERIAL_ADDER_SUB_EN adds a subtract port.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] input_a,
    input  logic [WIDTH-1:0] input_b,
    input  logic             carry_in,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             subtract,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    localparam int c_steps = WIDTH / DIGIT;
    localparam int c_cnt_w = $clog2(c_steps + 1);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_steps - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [WIDTH-1:0]     r_psum;
    logic                 r_carry;
    logic [c_cnt_w-1:0]   r_count;
    logic [WIDTH-1:0]     r_sum;
    logic                 r_carry_out;

    logic                 w_busy;
    logic                 w_done;
    logic                 w_load;
    logic                 w_last;
    logic [DIGIT:0]       w_slice;
    logic [WIDTH-1:0]     w_psum_next;
    logic [WIDTH-1:0]     w_b_load;
    logic                 w_cin_load;

`ifdef SERIAL_ADDER_SUB_EN
    // Two's-complement subtraction: A + ~B + 1, carry_in is ignored.
    assign w_b_load   = subtract ? ~input_b : input_b;
    assign w_cin_load = subtract ? 1'b1 : carry_in;
`else
    assign w_b_load   = input_b;
    assign w_cin_load = carry_in;
`endif

    assign w_slice = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]}
                   + {{DIGIT{1'b0}}, r_carry};

    // The new slice enters at the top, so after all steps the first slice is at bit 0.
    assign w_psum_next = (r_psum >> DIGIT)
                       | (WIDTH'(w_slice[DIGIT-1:0]) << (WIDTH - DIGIT));

    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        w_load       = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_state_next = RUN;
                end
            end
            RUN: begin
                w_busy = 1'b1;
                if (r_count == c_last) begin
                    w_last       = 1'b1;
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_done = 1'b1;
                if (start) begin
                    w_load       = 1'b1;
                    w_state_next = RUN;
                end else begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_psum      <= '0;
            r_carry     <= 1'b0;
            r_count     <= '0;
            r_sum       <= '0;
            r_carry_out <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_load) begin
                r_a     <= input_a;
                r_b     <= w_b_load;
                r_carry <= w_cin_load;
                r_psum  <= '0;
                r_count <= '0;
            end else if (r_state == RUN) begin
                r_a     <= r_a >> DIGIT;
                r_b     <= r_b >> DIGIT;
                r_carry <= w_slice[DIGIT];
                r_psum  <= w_psum_next;
                r_count <= w_last ? '0 : r_count + c_cnt_w'(1);
            end
            if (w_last) begin
                r_sum       <= w_psum_next;
                r_carry_out <= w_slice[DIGIT];
            end
        end
    end

    assign busy      = w_busy;
    assign done      = w_done;
    assign sum       = r_sum;
    assign carry_out = r_carry_out;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder
// Description : Scoreboard bench for serial_adder, DIGIT=1 and DIGIT=4 builds.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] input_a;
    logic [7:0] input_b;
    logic       carry_in;
    logic       subtract;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       carry_out;

    logic       start4;
    logic [7:0] a4;
    logic [7:0] b4;
    logic       c4;
    logic       busy4;
    logic       done4;
    logic [7:0] sum4;
    logic       cout4;

    int checks = 0;
    int errors = 0;
    logic [8:0] exp_q[$];

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8), .DIGIT(1)) u_dut (
        .clock     (clk),
        .reset     (rst),
        .start     (start),
        .input_a   (input_a),
        .input_b   (input_b),
        .carry_in  (carry_in),
`ifdef SERIAL_ADDER_SUB_EN
        .subtract  (subtract),
`endif
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .carry_out (carry_out)
    );

    serial_adder #(.WIDTH(8), .DIGIT(4)) u_dut4 (
        .clock     (clk),
        .reset     (rst),
        .start     (start4),
        .input_a   (a4),
        .input_b   (b4),
        .carry_in  (c4),
`ifdef SERIAL_ADDER_SUB_EN
        .subtract  (1'b0),
`endif
        .busy      (busy4),
        .done      (done4),
        .sum       (sum4),
        .carry_out (cout4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b,
                                         input logic cin, input logic sub);
        if (sub) return {1'b0, a} + {1'b0, ~b} + 9'd1;
        return {1'b0, a} + {1'b0, b} + {8'd0, cin};
    endfunction

    // Scoreboard: every done pulse pops one expected result.
    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                check("sum", {24'd0, sum}, {24'd0, e[7:0]});
                check("carry_out", {31'd0, carry_out}, {31'd0, e[8]});
            end
        end
        if (busy && done) check("busy_done_overlap", 32'd1, 32'd0);
    end

    task automatic drive_start(input logic [7:0] a, input logic [7:0] b,
                               input logic cin, input logic sub);
        input_a  = a;
        input_b  = b;
        carry_in = cin;
        subtract = sub;
        start    = 1'b1;
        exp_q.push_back(model(a, b, cin, sub));
    endtask

    task automatic do_add(input logic [7:0] a, input logic [7:0] b,
                          input logic cin, input logic sub);
        int n;
        int g;
        @(negedge clk);
        drive_start(a, b, cin, sub);
        @(negedge clk);
        start = 1'b0;
        n = 0;
        g = 0;
        while (!done && g < 40) begin
            if (busy) n++;
            g++;
            @(negedge clk);
        end
        check("done_seen", {31'd0, done}, 32'd1);
        check("busy_cycles", n, 32'd8);
    endtask

    initial begin
        int n;
        int cnt;
        rst      = 1'b1;
        start    = 1'b0;
        input_a  = '0;
        input_b  = '0;
        carry_in = 1'b0;
        subtract = 1'b0;
        start4   = 1'b0;
        a4       = '0;
        b4       = '0;
        c4       = 1'b0;
        #12;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_sum", {24'd0, sum}, 32'd0);
        check("rst_cout", {31'd0, carry_out}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        do_add(8'h3C, 8'h5A, 1'b0, 1'b0);
        do_add(8'hFF, 8'h01, 1'b0, 1'b0);
        do_add(8'h00, 8'h00, 1'b1, 1'b0);

        // Start in cycle 3 ignored; start in done cycle launches back-to-back run.
        @(negedge clk);
        drive_start(8'h12, 8'h34, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start    = 1'b1;
        input_a  = 8'hAA;
        input_b  = 8'h55;
        carry_in = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("first_done", {31'd0, done}, 32'd1);
        drive_start(8'h80, 8'h80, 1'b1, 1'b0);
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                start = 1'b0;
                check("b2b_busy", {31'd0, busy}, 32'd1);
            end
            if (done) break;
        end
        check("b2b_latency", n, 32'd9);

        // Asynchronous reset in cycle 4 of a run.
        @(negedge clk);
        drive_start(8'h77, 8'h11, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_sum", {24'd0, sum}, 32'd0);
        check("abort_cout", {31'd0, carry_out}, 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) cnt++;
        end
        check("no_done_after_abort", cnt, 32'd0);

        for (int i = 0; i < 4; i++)
            do_add(8'($urandom), 8'($urandom), 1'($urandom), 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
        do_add(8'h05, 8'h07, 1'b0, 1'b1);
        do_add(8'h07, 8'h05, 1'b0, 1'b1);
        do_add(8'h07, 8'h05, 1'b1, 1'b0);
`endif

        // DIGIT=4 instance: two busy cycles, done in cycle 3.
        @(negedge clk);
        a4     = 8'hA7;
        b4     = 8'h6B;
        c4     = 1'b1;
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        n   = 0;
        cnt = 0;
        while (!done4 && cnt < 20) begin
            if (busy4) n++;
            cnt++;
            @(negedge clk);
        end
        check("d4_done", {31'd0, done4}, 32'd1);
        check("d4_busy_cycles", n, 32'd2);
        check("d4_sum", {24'd0, sum4}, 32'h13);
        check("d4_cout", {31'd0, cout4}, 32'd1);

        @(negedge clk);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
